// File: rtl/cronometro_volta_if.sv
// Command and display bundle of the lap stopwatch.
// master drives the commands; slave is the stopwatch.
interface cronometro_volta_if #(
    parameter int DIGITOS = 4
);
    logic                 contar;
    logic                 pausar;
    logic                 parar;
    logic                 volta;
    logic                 modo;
    logic [4*DIGITOS-1:0] carga;
    logic [7*DIGITOS-1:0] segmentos;
    logic                 contando;
    logic                 volta_ativa;
    logic                 fim;
    logic                 estouro;

    modport master (
        output contar, pausar, parar, volta, modo, carga,
        input  segmentos, contando, volta_ativa, fim, estouro
    );

    modport slave (
        input  contar, pausar, parar, volta, modo, carga,
        output segmentos, contando, volta_ativa, fim, estouro
    );
endinterface

// File: rtl/cronometro_volta.sv
// BCD up/down stopwatch with lap freeze and registered
// active-low seven-segment output.
module cronometro_volta #(
    parameter int DIGITOS = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    cronometro_volta_if.slave bus
);
    localparam int NB = 4 * DIGITOS;
    localparam int NS = 7 * DIGITOS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [NB-1:0] NINES = {DIGITOS{4'h9}};
    localparam logic [NS-1:0] SEG_ZERO = {DIGITOS{7'b1000000}};

    typedef enum logic [1:0] {
        PARADO, CONTANDO, PAUSADO, FIM
    } estado_t;

    function automatic logic [NB-1:0] bcd_inc(
        input logic [NB-1:0] v);
        logic       c;
        logic [3:0] d;
        bcd_inc = v;
        c = 1'b1;
        for (int i = 0; i < DIGITOS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d == 4'd9) d = 4'd0;
                else begin
                    d = d + 4'd1;
                    c = 1'b0;
                end
            end
            bcd_inc[4*i +: 4] = d;
        end
    endfunction

    function automatic logic [NB-1:0] bcd_dec(
        input logic [NB-1:0] v);
        logic       b;
        logic [3:0] d;
        bcd_dec = v;
        b = 1'b1;
        for (int i = 0; i < DIGITOS; i++) begin
            d = v[4*i +: 4];
            if (b) begin
                if (d == 4'd0) d = 4'd9;
                else begin
                    d = d - 4'd1;
                    b = 1'b0;
                end
            end
            bcd_dec[4*i +: 4] = d;
        end
    endfunction

    // Out-of-range preset nibbles saturate to 9
    function automatic logic [NB-1:0] bcd_fix(
        input logic [NB-1:0] v);
        bcd_fix = v;
        for (int i = 0; i < DIGITOS; i++)
            if (v[4*i +: 4] > 4'd9) bcd_fix[4*i +: 4] = 4'd9;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    estado_t         r_state, w_state_nxt;
    logic [NB-1:0]   r_cnt, w_cnt_nxt;
    logic [NB-1:0]   r_lap, w_lap_nxt;
    logic [PW-1:0]   r_pre, w_pre_nxt;
    logic            r_dir, w_dir_nxt;
    logic            r_va, w_va_nxt;
    logic            r_est, w_est_nxt;
    logic [NS-1:0]   r_seg, w_seg_nxt;
    logic [NB-1:0]   w_inc, w_dec, w_disp;
    logic            w_tick, w_zero;

    assign w_inc  = bcd_inc(r_cnt);
    assign w_dec  = bcd_dec(r_cnt);
    assign w_zero = (r_cnt == '0);
    assign w_tick = (r_state == CONTANDO) && (r_pre == PRE_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lap_nxt   = r_lap;
        w_pre_nxt   = r_pre;
        w_dir_nxt   = r_dir;
        w_va_nxt    = r_va;
        w_est_nxt   = 1'b0;
        if (bus.parar) begin
            w_state_nxt = PARADO;
            w_cnt_nxt   = '0;
            w_pre_nxt   = '0;
            w_va_nxt    = 1'b0;
        end else begin
            unique case (r_state)
                PARADO: if (bus.contar) begin
                    w_state_nxt = CONTANDO;
                    w_dir_nxt   = bus.modo;
                    if (bus.modo) w_cnt_nxt = bcd_fix(bus.carga);
                end
                CONTANDO: begin
                    w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
                    if (bus.pausar) w_state_nxt = PAUSADO;
                    if (r_dir && w_zero) begin
                        if (!bus.pausar) w_state_nxt = FIM;
                    end else if (w_tick && r_dir) begin
                        w_cnt_nxt = w_dec;
                        if (w_dec == '0 && !bus.pausar)
                            w_state_nxt = FIM;
                    end else if (w_tick) begin
                        w_cnt_nxt = w_inc;
                        w_est_nxt = (r_cnt == NINES);
                    end
                end
                PAUSADO: if (bus.contar) w_state_nxt = CONTANDO;
                FIM: ;
            endcase
            if (bus.volta && (r_state == CONTANDO ||
                              r_state == PAUSADO)) begin
                w_va_nxt = ~r_va;
                if (!r_va) w_lap_nxt = r_cnt;
            end
        end
    end

    always_comb begin
        w_disp    = r_va ? r_lap : r_cnt;
        w_seg_nxt = '0;
        for (int i = 0; i < DIGITOS; i++)
            w_seg_nxt[7*i +: 7] = glyph(w_disp[4*i +: 4]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= PARADO;
            r_cnt   <= '0;
            r_lap   <= '0;
            r_pre   <= '0;
            r_dir   <= 1'b0;
            r_va    <= 1'b0;
            r_est   <= 1'b0;
            r_seg   <= SEG_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lap   <= w_lap_nxt;
            r_pre   <= w_pre_nxt;
            r_dir   <= w_dir_nxt;
            r_va    <= w_va_nxt;
            r_est   <= w_est_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign bus.segmentos   = r_seg;
    assign bus.contando    = (r_state == CONTANDO);
    assign bus.fim         = (r_state == FIM);
    assign bus.volta_ativa = r_va;
    assign bus.estouro     = r_est;
endmodule

// File: tb/tb_cronometro_volta.sv
// Directed bench for cronometro_volta with DIGITOS=4, CLK_DIV=2.
module tb_cronometro_volta;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    cronometro_volta_if #(.DIGITOS(4)) bus ();

    cronometro_volta #(
        .DIGITOS(4),
        .CLK_DIV(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        c, p, s, vl, m;
        logic [15:0] cg;
        logic        ec, eva, ef, ee;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic c, p, s, vl, m,
        input logic [15:0] cg,
        input logic ec, eva, ef, ee,
        input logic [15:0] ed);
        vec_t r;
        r.c = c; r.p = p; r.s = s; r.vl = vl; r.m = m;
        r.cg = cg;
        r.ec = ec; r.eva = eva; r.ef = ef; r.ee = ee;
        r.ed = ed;
        return r;
    endfunction

    function automatic logic [6:0] gl(input logic [3:0] d);
        case (d)
            4'd0: gl = 7'h40;
            4'd1: gl = 7'h79;
            4'd2: gl = 7'h24;
            4'd3: gl = 7'h30;
            4'd4: gl = 7'h19;
            4'd5: gl = 7'h12;
            4'd6: gl = 7'h02;
            4'd7: gl = 7'h78;
            4'd8: gl = 7'h00;
            4'd9: gl = 7'h10;
            default: gl = 7'h7f;
        endcase
    endfunction

    function automatic logic [31:0] expv(
        input logic c, va, f, e,
        input logic [15:0] d);
        logic [27:0] s;
        for (int i = 0; i < 4; i++) s[7*i +: 7] = gl(d[4*i +: 4]);
        return {c, va, f, e, s};
    endfunction

    function automatic logic [31:0] outs();
        return {bus.contando, bus.volta_ativa, bus.fim,
                bus.estouro, bus.segmentos};
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] got, exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic c, p, s, vl, m,
                         input logic [15:0] cg);
        @(negedge clock);
        bus.contar = c;
        bus.pausar = p;
        bus.parar  = s;
        bus.volta  = vl;
        bus.modo   = m;
        bus.carga  = cg;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        bus.contar = 0; bus.pausar = 0; bus.parar = 0;
        bus.volta = 0; bus.modo = 0; bus.carga = '0;

        // up count, then pausar+contar, then all three at once
        tbl.push_back(v(1,0,0,0,0,16'h0000, 1,0,0,0,16'h0000));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0000));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0000));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0001));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0001));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0002));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0002));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0003));
        tbl.push_back(v(1,1,0,0,0,16'h0000, 0,0,0,0,16'h0003));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 0,0,0,0,16'h0004));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 0,0,0,0,16'h0004));
        tbl.push_back(v(1,1,1,0,0,16'h0000, 0,0,0,0,16'h0004));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 0,0,0,0,16'h0000));
        // down count to FIM
        tbl.push_back(v(1,0,0,0,1,16'h0002, 1,0,0,0,16'h0000));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0002));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0002));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 1,0,0,0,16'h0001));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 0,0,1,0,16'h0001));
        tbl.push_back(v(1,0,0,0,0,16'h0000, 0,0,1,0,16'h0000));
        tbl.push_back(v(0,1,0,0,0,16'h0000, 0,0,1,0,16'h0000));
        tbl.push_back(v(0,0,0,1,0,16'h0000, 0,0,1,0,16'h0000));
        tbl.push_back(v(0,0,1,0,0,16'h0000, 0,0,0,0,16'h0000));
        // zero preset goes straight to FIM
        tbl.push_back(v(1,0,0,0,1,16'h0000, 1,0,0,0,16'h0000));
        tbl.push_back(v(0,0,0,0,0,16'h0000, 0,0,1,0,16'h0000));
        tbl.push_back(v(0,0,1,0,0,16'h0000, 0,0,0,0,16'h0000));
        // non-BCD preset, modo/carga ignored while counting
        tbl.push_back(v(1,0,0,0,1,16'h00AF, 1,0,0,0,16'h0000));
        tbl.push_back(v(0,0,0,0,0,16'h1234, 1,0,0,0,16'h0099));
        tbl.push_back(v(0,0,0,0,0,16'h1234, 1,0,0,0,16'h0099));
        tbl.push_back(v(0,0,0,0,0,16'h1234, 1,0,0,0,16'h0098));
        tbl.push_back(v(0,0,1,0,0,16'h0000, 0,0,0,0,16'h0098));
        tbl.push_back(v(0,0,0,1,0,16'h0000, 0,0,0,0,16'h0000));

        #12;
        chk("reset_hold", outs(), expv(0,0,0,0,16'h0000));
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].c, tbl[i].p, tbl[i].s, tbl[i].vl,
                  tbl[i].m, tbl[i].cg);
            chk($sformatf("vec%0d", i), outs(),
                expv(tbl[i].ec, tbl[i].eva, tbl[i].ef,
                     tbl[i].ee, tbl[i].ed));
        end

        // up-mode wrap from 9999
        drive(1, 0, 0, 0, 0, 16'h0);
        idle(19998);
        idle(1);
        chk("pre_wrap", outs(), expv(1,0,0,0,16'h9999));
        idle(1);
        chk("wrap", outs(), expv(1,0,0,1,16'h9999));
        idle(1);
        chk("wrap_end", outs(), expv(1,0,0,0,16'h0000));
        drive(0, 0, 1, 0, 0, 16'h0);
        chk("wrap_parar", outs(), expv(0,0,0,0,16'h0000));

        // lap freeze, pause, resume with prescaler phase kept
        drive(1, 0, 0, 0, 0, 16'h0);
        idle(10);
        drive(0, 0, 0, 1, 0, 16'h0);
        chk("lap_set", outs(), expv(1,1,0,0,16'h0005));
        idle(5);
        chk("lap_frozen", outs(), expv(1,1,0,0,16'h0005));
        drive(0, 1, 0, 0, 0, 16'h0);
        chk("pause", outs(), expv(0,1,0,0,16'h0005));
        idle(2);
        chk("paused", outs(), expv(0,1,0,0,16'h0005));
        drive(1, 0, 0, 0, 0, 16'h0);
        chk("resume", outs(), expv(1,1,0,0,16'h0005));
        drive(0, 0, 0, 1, 0, 16'h0);
        chk("lap_clear", outs(), expv(1,0,0,0,16'h0005));
        idle(1);
        chk("live", outs(), expv(1,0,0,0,16'h0009));

        // asynchronous reset with lap active
        drive(0, 0, 0, 1, 0, 16'h0);
        chk("lap_again", outs(), expv(1,1,0,0,16'h0009));
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", outs(), expv(0,0,0,0,16'h0000));
        @(negedge clock);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 16'h0);
        chk("post_reset", outs(), expv(1,0,0,0,16'h0000));
        idle(2);
        chk("post_reset_run", outs(), expv(1,0,0,0,16'h0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
